line_burst_adaptor: RTL

//  Responder on the 256-bit cache-line interface driven by the I/D arbiter (mem_*_l2 side).

---
 rtl/line_burst_adaptor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/line_burst_adaptor.sv
`timescale 1ns/1ps
// line_burst_adaptor
//   Converts single cache-line read/write requests from the arbiter into
//   BEATS-long beat bursts on the physical memory port. One full line is
//   buffered in each direction.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   line_read, line_write   level requests, held until line_resp
//   line_addr, line_wdata   line byte address and write line
//   line_resp, line_rdata   one-cycle completion pulse, last read line (held)
//   pmem_read, pmem_write   burst requests, held for the whole burst
//   pmem_address            line-aligned burst address
//   pmem_wdata              current write beat
//   pmem_rdata, pmem_resp   read beat and per-beat handshake
module line_burst_adaptor #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_read,
  input  logic              line_write,
  input  logic [ADDR_W-1:0] line_addr,
  input  logic [LINE_W-1:0] line_wdata,
  output logic              line_resp,
  output logic [LINE_W-1:0] line_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [BEAT_W-1:0] pmem_wdata,
  input  logic [BEAT_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned BEATS = LINE_W / BEAT_W;
  localparam int unsigned CNT_W = $clog2(BEATS);
  localparam int unsigned OFS   = $clog2(LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   beat_cnt;
  logic [LINE_W-1:0]  rbuf;
  logic [LINE_W-1:0]  wbuf;
  logic [LINE_W-1:0]  rd_line_c;
  logic [ADDR_W-1:0]  aligned_addr_c;
  logic               last_beat_c;
  logic               unused_addr_bits;

  assign aligned_addr_c   = {line_addr[ADDR_W-1:OFS], OFS'(0)};
  assign last_beat_c      = (beat_cnt == CNT_W'(BEATS - 1));
  assign unused_addr_bits = ^line_addr[OFS-1:0];

  // Read line with the incoming beat merged into its slot
  always_comb begin
    rd_line_c = rbuf;
    for (int k = 0; k < BEATS; k++) begin
      if (beat_cnt == CNT_W'(k)) begin
        rd_line_c[k*BEAT_W +: BEAT_W] = pmem_rdata;
      end
    end
  end

  // Burst FSM; every output is a register updated alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      rbuf         <= '0;
      wbuf         <= '0;
      line_resp    <= 1'b0;
      line_rdata   <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Read has priority when both requests are present
          if (line_read) begin
            state        <= RD_BURST;
            beat_cnt     <= '0;
            pmem_read    <= 1'b1;
            pmem_address <= aligned_addr_c;
          end else if (line_write) begin
            state        <= WR_BURST;
            beat_cnt     <= '0;
            pmem_write   <= 1'b1;
            pmem_address <= aligned_addr_c;
            wbuf         <= line_wdata;
            pmem_wdata   <= line_wdata[BEAT_W-1:0];
          end
        end
        RD_BURST: begin
          if (pmem_resp) begin
            rbuf     <= rd_line_c;
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (last_beat_c) begin
              state      <= DONE;
              pmem_read  <= 1'b0;
              line_resp  <= 1'b1;
              line_rdata <= rd_line_c;
            end
          end
        end
        WR_BURST: begin
          // wbuf shifts down so the next beat is always in the low slots
          if (pmem_resp) begin
            wbuf       <= wbuf >> BEAT_W;
            pmem_wdata <= wbuf[BEAT_W +: BEAT_W];
            beat_cnt   <= beat_cnt + CNT_W'(1);
            if (last_beat_c) begin
              state      <= DONE;
              pmem_write <= 1'b0;
              line_resp  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          line_resp <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
